// File: rtl/cin_mapping.sv
// Streams rows from one of two BRAMs, remaps the lanes of each row and skews
// them diagonally onto the input lanes of the systolic array.
module cin_mapping #(
  parameter int unsigned X      = 4,
  parameter int unsigned Y      = 4,
  parameter int unsigned L      = 4,
  parameter int unsigned RSA_DW = 16,
  parameter int unsigned RSA_AW = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  src_sel,
  input  logic [2:0]            map_mode,
  input  logic [RSA_AW-1:0]     base_addr,
  input  logic [7:0]            len,
  output logic                  TB_enb,
  output logic [RSA_AW-1:0]     TB_addrb,
  input  logic [L*RSA_DW-1:0]   TB_doutb,
  output logic                  CB_enb,
  output logic [RSA_AW-1:0]     CB_addrb,
  input  logic [L*RSA_DW-1:0]   CB_doutb,
  output logic [Y*RSA_DW-1:0]   A_data,
  output logic [Y-1:0]          A_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DRAIN_CYC = RD_LAT + Y;
  localparam int unsigned DCW       = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  if (X == 0 || Y < 2 || Y > L || L < 4 || RD_LAT == 0) begin : g_cfg_err
    $error("cin_mapping: unsupported X/Y/L/RD_LAT configuration");
  end

  state_e              state_q, state_d;
  logic                src_q, src_d;
  logic [2:0]          mode_q, mode_d;
  logic [7:0]          len_q, len_d;
  logic [RSA_AW-1:0]   addr_q, addr_d;
  logic [7:0]          iss_q, iss_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;
  logic                tb_enb_q, tb_enb_d, cb_enb_q, cb_enb_d;
  logic [RSA_AW-1:0]   tb_addrb_q, tb_addrb_d, cb_addrb_q, cb_addrb_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic                mv_q, mv_d;
  logic [RSA_DW-1:0]   m_q [Y];
  logic [RSA_DW-1:0]   m_d [Y];
  logic [RSA_DW-1:0]   d   [L];
  logic [RSA_DW-1:0]   mrow [Y];
  logic                rd;

  // Transfer sequencing: issue len reads, then drain the read latency and skew.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    mode_d  = mode_q;
    len_d   = len_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_sel;
          mode_d  = map_mode;
          len_d   = len;
          addr_d  = base_addr;
          iss_d   = 8'd1;
          state_d = (len != 8'd0) ? READ : DONE;
        end
      end
      READ: begin
        if (iss_q == len_q) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          addr_d = addr_q + RSA_AW'(1);
          iss_d  = iss_q + 8'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DCW'(DRAIN_CYC - 1)) state_d = DONE;
        else dcnt_d = dcnt_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd         = (state_d == READ);
    tb_enb_d   = rd & ~src_d;
    cb_enb_d   = rd & src_d;
    tb_addrb_d = tb_enb_d ? addr_d : '0;
    cb_addrb_d = cb_enb_d ? addr_d : '0;
    busy_d     = (state_d == READ) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // Read-valid pipeline matching the BRAM latency.
  always_comb begin
    pipe_d[0] = tb_enb_q | cb_enb_q;
    for (int unsigned s = 1; s < RD_LAT; s++) pipe_d[s] = pipe_q[s-1];
  end

  always_comb begin
    for (int unsigned j = 0; j < L; j++)
      d[j] = src_q ? CB_doutb[j*RSA_DW +: RSA_DW] : TB_doutb[j*RSA_DW +: RSA_DW];
  end

  // Lane remapping; codes 010/011 emit zero rows that still carry valid.
  always_comb begin
    for (int unsigned i = 0; i < Y; i++) mrow[i] = '0;
    case (mode_q)
      3'b000: for (int unsigned i = 0; i < Y; i++) if (i < L) mrow[i] = d[i];
      3'b001: for (int unsigned i = 0; i < Y; i++) if (i < L) mrow[i] = d[L-1-i];
      3'b111: begin mrow[0] = d[0]; mrow[1] = d[1]; end
      3'b100: begin mrow[0] = d[2]; mrow[1] = d[3]; end
      3'b101: begin mrow[0] = d[3]; mrow[1] = d[2]; end
      3'b110: begin mrow[0] = d[1]; mrow[1] = d[0]; end
      default: ;
    endcase
    mv_d = pipe_q[RD_LAT-1];
    for (int unsigned i = 0; i < Y; i++) m_d[i] = mv_d ? mrow[i] : '0;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      src_q      <= 1'b0;
      mode_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      iss_q      <= '0;
      dcnt_q     <= '0;
      tb_enb_q   <= 1'b0;
      cb_enb_q   <= 1'b0;
      tb_addrb_q <= '0;
      cb_addrb_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pipe_q     <= '0;
      mv_q       <= 1'b0;
      for (int unsigned i = 0; i < Y; i++) m_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      iss_q      <= iss_d;
      dcnt_q     <= dcnt_d;
      tb_enb_q   <= tb_enb_d;
      cb_enb_q   <= cb_enb_d;
      tb_addrb_q <= tb_addrb_d;
      cb_addrb_q <= cb_addrb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pipe_q     <= pipe_d;
      mv_q       <= mv_d;
      m_q        <= m_d;
    end
  end

  // Diagonal skew: lane i passes through i extra registers.
  for (genvar i = 0; i < Y; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign A_data[0 +: RSA_DW] = m_q[0];
      assign A_valid[0]          = mv_q;
    end else begin : g_dly
      logic [RSA_DW-1:0] sd_q [i];
      logic [RSA_DW-1:0] sd_d [i];
      logic [i-1:0]      sv_q, sv_d;
      always_comb begin
        sd_d[0] = m_q[i];
        sv_d[0] = mv_q;
        for (int s = 1; s < i; s++) begin
          sd_d[s] = sd_q[s-1];
          sv_d[s] = sv_q[s-1];
        end
      end
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          sv_q <= '0;
          for (int s = 0; s < i; s++) sd_q[s] <= '0;
        end else begin
          sv_q <= sv_d;
          sd_q <= sd_d;
        end
      end
      assign A_data[i*RSA_DW +: RSA_DW] = sd_q[i-1];
      assign A_valid[i]                 = sv_q[i-1];
    end
  end

  assign TB_enb   = tb_enb_q;
  assign CB_enb   = cb_enb_q;
  assign TB_addrb = tb_addrb_q;
  assign CB_addrb = cb_addrb_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cin_mapping.sv
// Randomised and directed bench for cin_mapping with a transaction-level model.
module tb_cin_mapping;

  localparam int unsigned X = 4, Y = 4, L = 4, DW = 16, AW = 10, RD_LAT = 2;
  localparam int unsigned RW = L * DW;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk, sys_rst_n, start, src_sel;
  logic [2:0]    map_mode;
  logic [AW-1:0] base_addr;
  logic [7:0]    len;
  logic          TB_enb, CB_enb;
  logic [AW-1:0] TB_addrb, CB_addrb;
  logic [RW-1:0] TB_doutb, CB_doutb;
  logic [Y*DW-1:0] A_data;
  logic [Y-1:0]  A_valid;
  logic          busy, done;

  int nvec = 0;
  int nerr = 0;

  cin_mapping #(.X(X), .Y(Y), .L(L), .RSA_DW(DW), .RSA_AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .src_sel(src_sel),
    .map_mode(map_mode), .base_addr(base_addr), .len(len),
    .TB_enb(TB_enb), .TB_addrb(TB_addrb), .TB_doutb(TB_doutb),
    .CB_enb(CB_enb), .CB_addrb(CB_addrb), .CB_doutb(CB_doutb),
    .A_data(A_data), .A_valid(A_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: RD_LAT-cycle read; garbage when not enabled.
  logic [RW-1:0] tb_mem [DEPTH];
  logic [RW-1:0] cb_mem [DEPTH];
  logic [RW-1:0] tb_pipe [RD_LAT];
  logic [RW-1:0] cb_pipe [RD_LAT];
  always @(posedge clk) begin
    tb_pipe[0] <= TB_enb ? tb_mem[TB_addrb] : RW'({$urandom, $urandom});
    cb_pipe[0] <= CB_enb ? cb_mem[CB_addrb] : RW'({$urandom, $urandom});
    for (int s = 1; s < RD_LAT; s++) begin
      tb_pipe[s] <= tb_pipe[s-1];
      cb_pipe[s] <= cb_pipe[s-1];
    end
  end
  assign TB_doutb = tb_pipe[RD_LAT-1];
  assign CB_doutb = cb_pipe[RD_LAT-1];

  // Current transaction as seen by the model.
  int m_src, m_mode, m_base, m_len;

  function automatic logic [DW-1:0] ref_lane(input logic [RW-1:0] row, input int mode, input int i);
    logic [DW-1:0] dd [L];
    for (int j = 0; j < L; j++) dd[j] = row[j*DW +: DW];
    case (mode)
      0: return dd[i];
      1: return dd[L-1-i];
      7: return (i == 0) ? dd[0] : (i == 1) ? dd[1] : '0;
      4: return (i == 0) ? dd[2] : (i == 1) ? dd[3] : '0;
      5: return (i == 0) ? dd[3] : (i == 1) ? dd[2] : '0;
      6: return (i == 0) ? dd[1] : (i == 1) ? dd[0] : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [RW-1:0] mem_row(input int a);
    return (m_src != 0) ? cb_mem[a] : tb_mem[a];
  endfunction

  // Row k is issued in cycle 1+k; lane i shows up RD_LAT+1+i cycles later.
  function automatic int row_at(input int c, input int i);
    return c - 1 - int'(RD_LAT) - 1 - i;
  endfunction

  function automatic logic [Y-1:0] exp_avalid(input int c);
    logic [Y-1:0] r = '0;
    for (int i = 0; i < Y; i++) begin
      int k;
      k = row_at(c, i);
      r[i] = (k >= 0 && k < m_len);
    end
    return r;
  endfunction

  function automatic logic [Y*DW-1:0] exp_adata(input int c);
    logic [Y*DW-1:0] r = '0;
    for (int i = 0; i < Y; i++) begin
      int k;
      k = row_at(c, i);
      if (k >= 0 && k < m_len) r[i*DW +: DW] = ref_lane(mem_row((m_base + k) % DEPTH), m_mode, i);
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_enb(input int c);
    logic on;
    on = (c >= 1 && c <= m_len);
    return {on && m_src == 0, on && m_src != 0};
  endfunction

  function automatic logic [2*AW-1:0] exp_addrs(input int c);
    logic [AW-1:0] a;
    logic [1:0] e;
    a = AW'((m_base + c - 1) % DEPTH);
    e = exp_enb(c);
    return {e[1] ? a : AW'(0), e[0] ? a : AW'(0)};
  endfunction

  function automatic logic [1:0] exp_bd(input int c);
    int last;
    last = (m_len == 0) ? 1 : m_len + int'(RD_LAT + Y) + 1;
    return {m_len != 0 && c >= 1 && c < last, c == last};
  endfunction

  function automatic int last_cycle();
    return (m_len == 0) ? 1 : m_len + int'(RD_LAT + Y) + 1;
  endfunction

  task automatic launch(input int src, input int mode, input int base, input int ln);
    @(negedge clk);
    m_src = src; m_mode = mode; m_base = base; m_len = ln;
    start = 1'b1; src_sel = src[0]; map_mode = 3'(mode);
    base_addr = AW'(base); len = 8'(ln);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      nvec++;
      if ({TB_enb, CB_enb, TB_addrb, CB_addrb, A_data, A_valid, busy, done} !== '0) begin
        nerr++; $display("FAIL reset_hold got av=%b busy=%b done=%b enb=%b%b", A_valid, busy, done, TB_enb, CB_enb);
      end
    end
    sys_rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      nvec++;
      if ({TB_enb, CB_enb, A_valid, busy, done} !== '0) begin
        nerr++; $display("FAIL reset_idle got av=%b busy=%b done=%b", A_valid, busy, done);
      end
    end
  endtask

  task automatic test_pos();
    int l0[3] = '{1, 5, 9};
    int l3[3] = '{4, 8, 12};
    for (int k = 0; k < 3; k++)
      tb_mem[5+k] = {DW'(4*k+4), DW'(4*k+3), DW'(4*k+2), DW'(4*k+1)};
    launch(0, 0, 5, 3);
    for (int c = 1; c <= last_cycle(); c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      nvec++; if ({TB_enb, CB_enb} !== exp_enb(c)) begin nerr++; $display("FAIL pos_enb c=%0d got %b want %b", c, {TB_enb, CB_enb}, exp_enb(c)); end
      nvec++; if ({TB_addrb, CB_addrb} !== exp_addrs(c)) begin nerr++; $display("FAIL pos_addr c=%0d got %h want %h", c, {TB_addrb, CB_addrb}, exp_addrs(c)); end
      nvec++; if (A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL pos_avalid c=%0d got %b want %b", c, A_valid, exp_avalid(c)); end
      nvec++; if (A_data !== exp_adata(c)) begin nerr++; $display("FAIL pos_adata c=%0d got %h want %h", c, A_data, exp_adata(c)); end
      nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL pos_busydone c=%0d got %b want %b", c, {busy, done}, exp_bd(c)); end
      if (c <= 3) begin
        nvec++; if (TB_addrb !== AW'(4 + c)) begin nerr++; $display("FAIL pos_addr_lit c=%0d got %0d want %0d", c, TB_addrb, 4 + c); end
      end
      if (c >= 4 && c <= 6) begin
        nvec++; if (A_data[DW-1:0] !== DW'(l0[c-4])) begin nerr++; $display("FAIL pos_lane0 c=%0d got %0d want %0d", c, A_data[DW-1:0], l0[c-4]); end
      end
      if (c >= 7 && c <= 9) begin
        nvec++; if (A_data[3*DW +: DW] !== DW'(l3[c-7])) begin nerr++; $display("FAIL pos_lane3 c=%0d got %0d want %0d", c, A_data[3*DW +: DW], l3[c-7]); end
      end
      if (c == 10) begin
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL pos_done_at_10 got %b want 1", done); end
      end
    end
  endtask

  task automatic test_modes();
    int modes[5] = '{1, 4, 5, 6, 7};
    int addrs[5] = '{100, 200, 200, 200, 200};
    int tab[5][4] = '{'{4, 3, 2, 1}, '{30, 40, 0, 0}, '{40, 30, 0, 0}, '{20, 10, 0, 0}, '{10, 20, 0, 0}};
    cb_mem[100] = {DW'(4), DW'(3), DW'(2), DW'(1)};
    cb_mem[200] = {DW'(40), DW'(30), DW'(20), DW'(10)};
    for (int n = 0; n < 5; n++) begin
      launch(1, modes[n], addrs[n], 1);
      for (int c = 1; c <= last_cycle(); c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        nvec++; if ({TB_enb, CB_enb} !== exp_enb(c)) begin nerr++; $display("FAIL mode%0d_enb c=%0d got %b want %b", modes[n], c, {TB_enb, CB_enb}, exp_enb(c)); end
        nvec++; if ({TB_addrb, CB_addrb} !== exp_addrs(c)) begin nerr++; $display("FAIL mode%0d_addr c=%0d got %h want %h", modes[n], c, {TB_addrb, CB_addrb}, exp_addrs(c)); end
        nvec++; if (A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL mode%0d_avalid c=%0d got %b want %b", modes[n], c, A_valid, exp_avalid(c)); end
        nvec++; if (A_data !== exp_adata(c)) begin nerr++; $display("FAIL mode%0d_adata c=%0d got %h want %h", modes[n], c, A_data, exp_adata(c)); end
        nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL mode%0d_busydone c=%0d got %b want %b", modes[n], c, {busy, done}, exp_bd(c)); end
        if (c >= 4 && c <= 7) begin
          nvec++;
          if (A_data[(c-4)*DW +: DW] !== DW'(tab[n][c-4]) || A_valid[c-4] !== 1'b1) begin
            nerr++; $display("FAIL mode%0d_lit lane=%0d got %0d/%b want %0d/1", modes[n], c - 4, A_data[(c-4)*DW +: DW], A_valid[c-4], tab[n][c-4]);
          end
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int reads;
    // len = 0
    launch(0, 0, 7, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      nvec++;
      if ({busy, done, TB_enb, CB_enb} !== ((c == 1) ? 4'b0100 : 4'b0000)) begin
        nerr++; $display("FAIL len0 c=%0d got busy/done/enb=%b", c, {busy, done, TB_enb, CB_enb});
      end
    end
    // address wrap, then start re-pulsed while busy
    cb_mem[1023] = RW'({$urandom, $urandom});
    cb_mem[0]    = RW'({$urandom, $urandom});
    for (int t = 0; t < 2; t++) begin
      if (t == 0) launch(1, 0, 1023, 2);
      else launch(0, 0, 40, 4);
      reads = 0;
      for (int c = 1; c <= last_cycle(); c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (t == 1 && c == 2) begin start = 1'b1; src_sel = 1'b1; base_addr = AW'(300); len = 8'd9; map_mode = 3'b001; end
        if (t == 1 && c == 3) start = 1'b0;
        if (TB_enb || CB_enb) reads++;
        nvec++; if ({TB_enb, CB_enb} !== exp_enb(c)) begin nerr++; $display("FAIL bnd%0d_enb c=%0d got %b want %b", t, c, {TB_enb, CB_enb}, exp_enb(c)); end
        nvec++; if ({TB_addrb, CB_addrb} !== exp_addrs(c)) begin nerr++; $display("FAIL bnd%0d_addr c=%0d got %h want %h", t, c, {TB_addrb, CB_addrb}, exp_addrs(c)); end
        nvec++; if (A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL bnd%0d_avalid c=%0d got %b want %b", t, c, A_valid, exp_avalid(c)); end
        nvec++; if (A_data !== exp_adata(c)) begin nerr++; $display("FAIL bnd%0d_adata c=%0d got %h want %h", t, c, A_data, exp_adata(c)); end
        nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL bnd%0d_busydone c=%0d got %b want %b", t, c, {busy, done}, exp_bd(c)); end
        if (t == 0 && c <= 2) begin
          nvec++; if (CB_addrb !== ((c == 1) ? AW'(1023) : AW'(0))) begin nerr++; $display("FAIL wrap_addr c=%0d got %0d", c, CB_addrb); end
        end
      end
      nvec++;
      if (reads != m_len) begin nerr++; $display("FAIL bnd%0d_reads got %0d want %0d", t, reads, m_len); end
    end
  endtask

  task automatic test_reset_mid();
    launch(0, 0, 50, 5);
    for (int c = 1; c <= m_len + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      nvec++; if (A_data !== exp_adata(c) || A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL rmid_pre c=%0d got %h/%b", c, A_data, A_valid); end
      nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL rmid_busy c=%0d got %b want %b", c, {busy, done}, exp_bd(c)); end
    end
    sys_rst_n = 1'b0;
    #1;
    nvec++;
    if ({TB_enb, CB_enb, TB_addrb, CB_addrb, A_data, A_valid, busy, done} !== '0) begin
      nerr++; $display("FAIL rmid_async got av=%b busy=%b done=%b data=%h", A_valid, busy, done, A_data);
    end
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nvec++;
      if ({TB_enb, CB_enb, A_valid, busy, done} !== '0) begin
        nerr++; $display("FAIL rmid_after c=%0d got enb=%b%b av=%b busy=%b done=%b", c, TB_enb, CB_enb, A_valid, busy, done);
      end
    end
    cb_mem[60] = RW'({$urandom, $urandom});
    cb_mem[61] = RW'({$urandom, $urandom});
    cb_mem[62] = RW'({$urandom, $urandom});
    launch(1, 0, 60, 3);
    for (int c = 1; c <= last_cycle(); c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      nvec++; if ({TB_addrb, CB_addrb} !== exp_addrs(c)) begin nerr++; $display("FAIL rmid_new_addr c=%0d got %h want %h", c, {TB_addrb, CB_addrb}, exp_addrs(c)); end
      nvec++; if (A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL rmid_new_avalid c=%0d got %b want %b", c, A_valid, exp_avalid(c)); end
      nvec++; if (A_data !== exp_adata(c)) begin nerr++; $display("FAIL rmid_new_adata c=%0d got %h want %h", c, A_data, exp_adata(c)); end
      nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL rmid_new_busydone c=%0d got %b want %b", c, {busy, done}, exp_bd(c)); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      launch(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)));
      for (int c = 1; c <= last_cycle(); c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (c > 1) begin
          src_sel = 1'($urandom); map_mode = 3'($urandom); base_addr = AW'($urandom); len = 8'($urandom);
        end
        nvec++; if ({TB_enb, CB_enb} !== exp_enb(c)) begin nerr++; $display("FAIL b2b%0d_enb c=%0d got %b want %b", n, c, {TB_enb, CB_enb}, exp_enb(c)); end
        nvec++; if ({TB_addrb, CB_addrb} !== exp_addrs(c)) begin nerr++; $display("FAIL b2b%0d_addr c=%0d got %h want %h", n, c, {TB_addrb, CB_addrb}, exp_addrs(c)); end
        nvec++; if (A_valid !== exp_avalid(c)) begin nerr++; $display("FAIL b2b%0d_avalid c=%0d got %b want %b", n, c, A_valid, exp_avalid(c)); end
        nvec++; if (A_data !== exp_adata(c)) begin nerr++; $display("FAIL b2b%0d_adata c=%0d got %h want %h", n, c, A_data, exp_adata(c)); end
        nvec++; if ({busy, done} !== exp_bd(c)) begin nerr++; $display("FAIL b2b%0d_busydone c=%0d got %b want %b", n, c, {busy, done}, exp_bd(c)); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; src_sel = 1'b0; map_mode = '0; base_addr = '0; len = '0;
    m_src = 0; m_mode = 0; m_base = 0; m_len = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      tb_mem[a] = RW'({$urandom, $urandom});
      cb_mem[a] = RW'({$urandom, $urandom});
    end
    test_reset();
    test_pos();
    test_modes();
    test_boundaries();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
